// File: rtl/store_data_packer_pkg.sv
// store_pkg: shared size encodings, lane constants and the packed store entry
// used by store_data_packer and store_lane_pack.
package store_pkg;

  localparam int unsigned ST_ADDR_MAX = 32;  // widest supported byte address
  localparam int unsigned NUM_LANES   = 4;   // byte lanes per 32-bit word
  localparam int unsigned LANE_W      = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } st_size_e;

  localparam logic [NUM_LANES-1:0] BE_NONE = 4'b0000;

  // One already-packed store, as held in the output and skid registers.
  typedef struct packed {
    logic [ST_ADDR_MAX-1:0]                   addr;
    logic [NUM_LANES-1:0][LANE_W-1:0]         wdata;
    logic [NUM_LANES-1:0]                     be;
    logic                                     misalign;
  } st_entry_t;

endpackage

// File: rtl/store_data_packer_if.sv
// Store request / packed-store handshake bundle between EX/MEM and data memory.
interface store_data_packer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [1:0]        in_size;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_wdata;
  logic [3:0]        out_be;
  logic              out_misalign;

  // Pipeline side driving requests and sinking packed stores.
  modport master (
    output in_valid, in_addr, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_wdata, out_be, out_misalign
  );

  // Packer side.
  modport slave (
    input  in_valid, in_addr, in_data, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_wdata, out_be, out_misalign
  );
endinterface

// File: rtl/store_data_packer_lane_pack.sv
// store_lane_pack: combinational store narrowing. Replicates the source data
// across byte lanes, builds byte enables and flags misaligned/reserved stores.
module store_lane_pack
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [1:0]        size_i,
  output st_entry_t         ent_o
);

  logic [1:0]           a;
  st_size_e             sz;
  logic [NUM_LANES-1:0] be_raw;
  logic                 mis;

  assign a  = addr_i[1:0];
  assign sz = st_size_e'(size_i);

  // Per-lane enables for byte and half stores; word enables every lane.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    always_comb begin
      be_raw[l] = 1'b0;
      case (sz)
        SZ_BYTE: be_raw[l] = (a == 2'(l));
        SZ_HALF: be_raw[l] = (a[1] == l[1]);
        SZ_WORD: be_raw[l] = 1'b1;
        default: be_raw[l] = 1'b0;
      endcase
    end
  end

  // Alignment check: reserved size is always treated as misaligned.
  always_comb begin
    mis = 1'b0;
    case (sz)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = a[0];
      SZ_WORD: mis = (a != 2'b00);
      default: mis = 1'b1;
    endcase
  end

  // Assemble the entry; a misaligned store keeps its data but writes no lane.
  always_comb begin
    ent_o          = '0;
    ent_o.addr     = ST_ADDR_MAX'({addr_i[ADDR_W-1:2], 2'b00});
    ent_o.misalign = mis;
    ent_o.be       = mis ? BE_NONE : be_raw;
    case (sz)
      SZ_BYTE: ent_o.wdata = {4{data_i[7:0]}};
      SZ_HALF: ent_o.wdata = {2{data_i[15:0]}};
      default: ent_o.wdata = data_i;
    endcase
  end

endmodule

// File: rtl/store_data_packer.sv
// store_data_packer: registered MEM-stage store packer with a 1-entry skid
// buffer. Optional saturating misalignment counter: STORE_PACKER_ERRCNT_EN.
module store_data_packer
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 Reset_L,
  store_data_packer_if.slave   bus
`ifdef STORE_PACKER_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]  err_count
`endif
);

  st_entry_t in_ent;
  st_entry_t or_q, or_d;
  st_entry_t sk_q, sk_d;
  logic      or_vld_q, or_vld_d;
  logic      sk_vld_q, sk_vld_d;
  logic      acc, xfer;

  store_lane_pack #(.ADDR_W(ADDR_W)) u_pack (
    .addr_i (bus.in_addr),
    .data_i (bus.in_data),
    .size_i (bus.in_size),
    .ent_o  (in_ent)
  );

  // in_ready comes straight from the skid valid flop, so it is registered.
  assign bus.in_ready     = ~sk_vld_q;
  assign acc              = bus.in_valid & ~sk_vld_q;
  assign xfer             = or_vld_q & bus.out_ready;

  assign bus.out_valid    = or_vld_q;
  assign bus.out_addr     = or_q.addr[ADDR_W-1:0];
  assign bus.out_wdata    = or_q.wdata;
  assign bus.out_be       = or_q.be;
  assign bus.out_misalign = or_q.misalign;

  // Next state of output/skid registers; skid drains before new requests.
  always_comb begin
    or_d     = or_q;
    sk_d     = sk_q;
    or_vld_d = or_vld_q;
    sk_vld_d = sk_vld_q;
    if (sk_vld_q) begin
      if (xfer) begin
        or_d     = sk_q;
        sk_vld_d = 1'b0;
      end
    end else if (acc) begin
      if (!or_vld_q || xfer) begin
        or_d     = in_ent;
        or_vld_d = 1'b1;
      end else begin
        sk_d     = in_ent;
        sk_vld_d = 1'b1;
      end
    end else if (xfer) begin
      or_vld_d = 1'b0;
    end
  end

  // Storage registers; reset discards both entries.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      or_q     <= '0;
      sk_q     <= '0;
      or_vld_q <= 1'b0;
      sk_vld_q <= 1'b0;
    end else begin
      or_q     <= or_d;
      sk_q     <= sk_d;
      or_vld_q <= or_vld_d;
      sk_vld_q <= sk_vld_d;
    end
  end

`ifdef STORE_PACKER_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  // Count accepted misaligned requests, holding at all-ones.
  always_comb begin
    errcnt_d = errcnt_q;
    if (acc && in_ent.misalign && (errcnt_q != '1))
      errcnt_d = errcnt_q + 1'b1;
  end

  // Misalignment counter register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) errcnt_q <= '0;
    else          errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: doc/store_data_packer.md
Name: store_data_packer

Overview:
- Memory-stage store-side narrowing block; the write-direction counterpart of immediate/load widening.
- Takes a 32-bit register value, byte address and access size from EX/MEM and produces word-aligned write data with replicated lanes and byte enables for the data memory.
- Registered stage with valid/ready handshakes on both sides and a 1-entry skid buffer, so MEM-stage stalls never drop or duplicate a store.
- Flags misaligned stores so the pipeline can raise an address-error exception.

Parameters:
- ADDR_W, 32: byte address width.
- ERRCNT_W, 16: width of the misalignment counter (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- Reset_L  in  1  asynchronous active-low reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  packer can accept a request.
- in_addr  in  ADDR_W  byte address.
- in_data  in  32  store source register value.
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- out_valid  out  1  packed store valid.
- out_ready  in  1  memory accepts the packed store.
- out_addr  out  ADDR_W  word address; bits [1:0] forced to 00.
- out_wdata  out  32  lane-replicated write data.
- out_be  out  4  byte enables; bit i enables byte lane i.
- out_misalign  out  1  request was misaligned or used a reserved size.
- err_count  out  ERRCNT_W  saturating misalignment count (present only with the macro).

Behaviour:
- Reset (Reset_L low, asynchronous): out_valid=0, out_addr=0, out_wdata=0, out_be=0, out_misalign=0, skid empty, in_ready=1, err_count=0.
- Transfers:
  - Input accept occurs when in_valid & in_ready at the rising edge.
  - Output transfer occurs when out_valid & out_ready.
  - Latency is 1 cycle: a request accepted at edge N is presented at the output after edge N.
  - Order is strictly preserved.
- Storage: output register (OR) plus skid register (SK).
  - in_ready is registered and equals ~SK.valid.
  - If OR is empty, or OR is transferring this cycle, and SK is empty: an accepted request loads OR.
  - If OR holds data and is not transferring: an accepted request loads SK; in_ready=0 from the next cycle.
  - If SK is full and OR transfers: SK moves to OR, SK empties, in_ready=1 next cycle.
  - Accept plus transfer in the same cycle with SK empty: OR is replaced by the new request, with no bubble.
  - Outputs hold stable while out_valid & ~out_ready.
  - Reset asserted mid-operation discards both entries.
- Packing, little-endian lanes, a = in_addr[1:0]:
  - Byte: wdata={4{data[7:0]}}; be=4'b0001<<a.
  - Half: wdata={2{data[15:0]}}; be=a[1] ? 1100 : 0011.
  - Word: wdata=data; be=1111.
- Misalignment:
  - Condition: half with a[0]=1, word with a!=00, or size=11.
  - Required response: out_misalign=1 and out_be=0000. The wdata packing still applies, and the request still passes through the handshake so the exception stays in order.

Optional Feature:
- Macro: STORE_PACKER_ERRCNT_EN.
- Defined:
  - err_count port exists.
  - It increments on each accepted misaligned request and saturates at all-ones.
  - It resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package store_pkg holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - Constant BE_NONE=4'b0000.
  - A packed-entry typedef {addr, wdata, be, misalign}.
- Sub-module store_lane_pack: purely combinational packing and misalignment check. It is instantiated once at the input, and both OR and SK store already-packed entries.

Test Plan:
- Byte store: in_addr=0x1003, data=0x12345678, size=00, out_ready=1. Expect one cycle later out_addr=0x1000, wdata=0x78787878, be=1000, misalign=0.
- Half store: addr=0x2002, data=0xAABBCCDD, size=01. Expect wdata=0xCCDDCCDD, be=1100. The same request with addr=0x2001 gives be=0000 and misalign=1. With the macro defined, err_count goes from 0 to 1.
- Back-pressure: three word stores A, B, C offered back-to-back with out_ready=0. Expect A in OR, B in SK, in_ready=0 on cycle 2 and C held. Raise out_ready: expect A, B, C delivered in order with no loss or duplication.
- Streaming: continuous in_valid with out_ready=1 for 8 cycles. Expect 8 outputs on consecutive cycles and in_ready constantly 1.
- Reserved size=11 at aligned addr=0x0. Expect be=0000 and misalign=1.
- Reset Reset_L low mid-cycle with OR and SK full. Expect out_valid=0 and in_ready=1 immediately, without waiting for CLK; no stale entry appears after release.
